// File: rtl/ex_srca_ctrl.sv
// ex_srca_ctrl
// -----------------------------------------------------------------------------
// Issue and operand-A scheduler for the 5-stage MIPS pipeline.
//
// A small shadow pipeline (EX, MEM) remembers the destination register of
// every instruction in flight. Each cycle the instruction sitting in ID is
// compared against it to decide:
//   * whether it may issue to EX (id_accept),
//   * whether fetch must hold for a load-use hazard (stall),
//   * whether the wrong-path fetch behind a jump must be squashed (flush),
//   * which ALU input-A source the instruction will use once it is in EX
//     (srca_sel, registered so it lines up with the instruction in EX).
//
// The WB stage never needs tracking. The register file writes in the first
// half of WB, so a WB match reads the fresh value straight from register A.
//
// Configuration macro:
//   SRCA_FWD_EN  defined   -> EX/MEM and MEM/WB forwarding; only a load in EX
//                             that feeds the ID instruction stalls (1 cycle).
//                undefined -> no forwarding; any EX or MEM match stalls until
//                             the producer reaches WB (up to 2 cycles), and
//                             srca_sel is only ever 0 or 3.
//
// Ports:
//   clock      in   pipeline clock, rising edge
//   resetn     in   asynchronous active-low reset
//   id_valid   in   ID holds a real instruction
//   id_op      in   [5:0] opcode of the ID instruction
//   id_rs      in   [4:0] source register feeding ALU input A
//   id_dst     in   [4:0] destination register, 0 = no write
//   id_accept  out  ID instruction moves to EX at this edge
//   stall      out  hold PC and IF/ID
//   flush      out  squash IF/ID contents
//   ex_valid   out  EX holds a real instruction (registered)
//   srca_sel   out  [1:0] ALU-A select for the EX instruction (registered):
//                   0 IDEXA, 1 EXMEMALUOut, 2 MEM/WB result, 3 IR[25:0]<<2
// -----------------------------------------------------------------------------
module ex_srca_ctrl #(
    parameter logic [5:0] OP_ALU  = 6'd0,
    parameter logic [5:0] OP_J    = 6'd2,
    parameter logic [5:0] OP_JAL  = 6'd3,
    parameter logic [5:0] OP_ADDI = 6'd8,
    parameter logic [5:0] OP_LW   = 6'd35,
    parameter logic [5:0] OP_SW   = 6'd43
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       id_valid,
    input  logic [5:0] id_op,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_dst,
    output logic       id_accept,
    output logic       stall,
    output logic       flush,
    output logic       ex_valid,
    output logic [1:0] srca_sel
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        STALL = 2'd1,
        FLUSH = 2'd2
    } state_t;

    localparam logic [1:0] SEL_REGA = 2'd0;
    localparam logic [1:0] SEL_EXMEM = 2'd1;
    localparam logic [1:0] SEL_MEMWB = 2'd2;
    localparam logic [1:0] SEL_JUMP = 2'd3;

    state_t     state_q, state_d;

    logic       ex_valid_q, ex_valid_d;
    logic [4:0] ex_dst_q, ex_dst_d;
    logic       mem_valid_q, mem_valid_d;
    logic [4:0] mem_dst_q, mem_dst_d;
    logic [1:0] srca_sel_q, srca_sel_d;
`ifdef SRCA_FWD_EN
    logic       ex_load_q, ex_load_d;
`endif

    logic       id_is_jump;
    logic       id_writes;
    logic [4:0] id_dst_eff;
    logic       hz_src;
    logic       ex_match;
    logic       mem_match;
    logic       hazard_stall;
    logic [1:0] sel_now;
    logic       accept_raw;
    logic       stall_raw;
    logic       flush_raw;

    // Decode and hazard detection for the ID instruction.
    // Only opcodes that actually write a register publish a destination into
    // the shadow pipeline; J and SW never write, whatever id_dst carries.
    // A jump's operand A is its own target field, so it never reads rs and
    // therefore never creates a hazard.
    always_comb begin
        id_is_jump = (id_op == OP_J) || (id_op == OP_JAL);
        id_writes  = (id_op == OP_ALU) || (id_op == OP_ADDI) ||
                     (id_op == OP_LW)  || (id_op == OP_JAL);
        if (id_op == OP_SW) begin
            id_writes = 1'b0;
        end
        id_dst_eff = id_writes ? id_dst : 5'd0;

        hz_src    = id_valid && (id_rs != 5'd0) && !id_is_jump;
        ex_match  = hz_src && ex_valid_q  && (ex_dst_q  == id_rs);
        mem_match = hz_src && mem_valid_q && (mem_dst_q == id_rs);

`ifdef SRCA_FWD_EN
        hazard_stall = ex_match && ex_load_q;
`else
        hazard_stall = ex_match || mem_match;
`endif

        // A load in EX never reaches the EX-match leg here: it stalls first
        // and is picked up from MEM/WB one cycle later.
        sel_now = SEL_REGA;
        if (id_is_jump) begin
            sel_now = SEL_JUMP;
`ifdef SRCA_FWD_EN
        end else if (ex_match) begin
            sel_now = SEL_EXMEM;
        end else if (mem_match) begin
            sel_now = SEL_MEMWB;
`endif
        end
    end

    // Issue FSM: next state and the combinational handshake outputs.
    // STALL keeps holding fetch only while the hazard is still present, so a
    // load-use hazard costs exactly one stall cycle and the held instruction
    // issues from STALL the moment its operand becomes forwardable.
    // The handshake outputs are forced low while resetn is asserted so the
    // whole block reads idle during reset.
    always_comb begin
        state_d    = state_q;
        accept_raw = 1'b0;
        stall_raw  = 1'b0;
        flush_raw  = 1'b0;

        case (state_q)
            RUN, STALL: begin
                accept_raw = id_valid && !hazard_stall;
                stall_raw  = hazard_stall;
                if (hazard_stall) begin
                    state_d = STALL;
                end else if (accept_raw && id_is_jump) begin
                    state_d = FLUSH;
                end else begin
                    state_d = RUN;
                end
            end
            FLUSH: begin
                flush_raw = 1'b1;
                state_d   = RUN;
            end
            default: begin
                state_d = RUN;
            end
        endcase

        id_accept = accept_raw && resetn;
        stall     = stall_raw  && resetn;
        flush     = flush_raw  && resetn;
    end

    // Shadow pipeline advance. A cycle without an accept pushes a bubble
    // into EX; MEM always takes whatever EX held.
    always_comb begin
        ex_valid_d  = id_accept;
        ex_dst_d    = id_accept ? id_dst_eff : 5'd0;
        mem_valid_d = ex_valid_q;
        mem_dst_d   = ex_dst_q;
        srca_sel_d  = id_accept ? sel_now : SEL_REGA;
`ifdef SRCA_FWD_EN
        ex_load_d   = id_accept && (id_op == OP_LW);
`endif
    end

    // State register and shadow pipeline flops.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q     <= RUN;
            ex_valid_q  <= 1'b0;
            ex_dst_q    <= 5'd0;
            mem_valid_q <= 1'b0;
            mem_dst_q   <= 5'd0;
            srca_sel_q  <= SEL_REGA;
`ifdef SRCA_FWD_EN
            ex_load_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            ex_valid_q  <= ex_valid_d;
            ex_dst_q    <= ex_dst_d;
            mem_valid_q <= mem_valid_d;
            mem_dst_q   <= mem_dst_d;
            srca_sel_q  <= srca_sel_d;
`ifdef SRCA_FWD_EN
            ex_load_q   <= ex_load_d;
`endif
        end
    end

    assign ex_valid = ex_valid_q;
    assign srca_sel = srca_sel_q;

endmodule

// File: tb/tb_ex_srca_ctrl.sv
// tb_ex_srca_ctrl
// -----------------------------------------------------------------------------
// Directed bench for ex_srca_ctrl. Each step drives one ID instruction just
// after a rising edge and checks every output at the following falling edge:
// the handshake outputs for the instruction being driven, and ex_valid /
// srca_sel for whatever was accepted on the previous edge. Expected values
// for both builds (SRCA_FWD_EN defined or not) are written out by hand.
// -----------------------------------------------------------------------------
module tb_ex_srca_ctrl;

    localparam logic [5:0] OP_ALU = 6'd0;
    localparam logic [5:0] OP_J   = 6'd2;
    localparam logic [5:0] OP_JAL = 6'd3;
    localparam logic [5:0] OP_LW  = 6'd35;

    logic       clock;
    logic       resetn;
    logic       id_valid;
    logic [5:0] id_op;
    logic [4:0] id_rs;
    logic [4:0] id_dst;
    logic       id_accept;
    logic       stall;
    logic       flush;
    logic       ex_valid;
    logic [1:0] srca_sel;

    int checks   = 0;
    int failures = 0;

    ex_srca_ctrl dut (
        .clock     (clock),
        .resetn    (resetn),
        .id_valid  (id_valid),
        .id_op     (id_op),
        .id_rs     (id_rs),
        .id_dst    (id_dst),
        .id_accept (id_accept),
        .stall     (stall),
        .flush     (flush),
        .ex_valid  (ex_valid),
        .srca_sel  (srca_sel)
    );

    // 10 ns pipeline clock.
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Drive one ID slot just after the rising edge.
    task automatic applyStimulus(input logic v, input logic [5:0] op,
                                 input logic [4:0] rs, input logic [4:0] dst);
        @(posedge clock);
        #1;
        id_valid = v;
        id_op    = op;
        id_rs    = rs;
        id_dst   = dst;
    endtask

    // One comparison, counted and reported on mismatch.
    task automatic checkOutput(input string tag, input logic [1:0] obs,
                               input logic [1:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Check all outputs at the falling edge of the current cycle.
    task automatic checkAll(input string name, input logic e_acc,
                            input logic e_stall, input logic e_flush,
                            input logic e_exv, input logic [1:0] e_sel);
        @(negedge clock);
        checkOutput({name, ".id_accept"}, {1'b0, id_accept}, {1'b0, e_acc});
        checkOutput({name, ".stall"},     {1'b0, stall},     {1'b0, e_stall});
        checkOutput({name, ".flush"},     {1'b0, flush},     {1'b0, e_flush});
        checkOutput({name, ".ex_valid"},  {1'b0, ex_valid},  {1'b0, e_exv});
        checkOutput({name, ".srca_sel"},  srca_sel,          e_sel);
    endtask

    task automatic step(input string name, input logic v, input logic [5:0] op,
                        input logic [4:0] rs, input logic [4:0] dst,
                        input logic e_acc, input logic e_stall,
                        input logic e_flush, input logic e_exv,
                        input logic [1:0] e_sel);
        applyStimulus(v, op, rs, dst);
        checkAll(name, e_acc, e_stall, e_flush, e_exv, e_sel);
    endtask

    initial begin
        // Reset with a valid instruction presented: everything must read 0.
        resetn   = 1'b0;
        id_valid = 1'b1;
        id_op    = OP_ALU;
        id_rs    = 5'd1;
        id_dst   = 5'd3;
        @(negedge clock);
        checkAll("reset", 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
        @(posedge clock);
        #1;
        resetn   = 1'b1;
        id_valid = 1'b0;

        step("idle0", 0, OP_ALU, 5'd0, 5'd0, 0, 0, 0, 0, 2'd0);

        // ADD r3 followed by a reader of r3.
        step("a1", 1, OP_ALU, 5'd1, 5'd3, 1, 0, 0, 0, 2'd0);
`ifdef SRCA_FWD_EN
        step("a2", 1, OP_ALU, 5'd3, 5'd6, 1, 0, 0, 1, 2'd0);
        step("a3", 0, OP_ALU, 5'd0, 5'd0, 0, 0, 0, 1, 2'd1);
        step("a4", 0, OP_ALU, 5'd0, 5'd0, 0, 0, 0, 0, 2'd0);
`else
        step("a2", 1, OP_ALU, 5'd3, 5'd6, 0, 1, 0, 1, 2'd0);
        step("a3", 1, OP_ALU, 5'd3, 5'd6, 0, 1, 0, 0, 2'd0);
        step("a4", 1, OP_ALU, 5'd3, 5'd6, 1, 0, 0, 0, 2'd0);
        step("a5", 0, OP_ALU, 5'd0, 5'd0, 0, 0, 0, 1, 2'd0);
        step("a6", 0, OP_ALU, 5'd0, 5'd0, 0, 0, 0, 0, 2'd0);
`endif
        step("drainA", 0, OP_ALU, 5'd0, 5'd0, 0, 0, 0, 0, 2'd0);

        // LW r5 followed immediately by a reader of r5.
        step("b1", 1, OP_LW,  5'd1, 5'd5, 1, 0, 0, 0, 2'd0);
        step("b2", 1, OP_ALU, 5'd5, 5'd7, 0, 1, 0, 1, 2'd0);
`ifdef SRCA_FWD_EN
        step("b3", 1, OP_ALU, 5'd5, 5'd7, 1, 0, 0, 0, 2'd0);
        step("b4", 0, OP_ALU, 5'd0, 5'd0, 0, 0, 0, 1, 2'd2);
        step("b5", 0, OP_ALU, 5'd0, 5'd0, 0, 0, 0, 0, 2'd0);
`else
        step("b3", 1, OP_ALU, 5'd5, 5'd7, 0, 1, 0, 0, 2'd0);
        step("b4", 1, OP_ALU, 5'd5, 5'd7, 1, 0, 0, 0, 2'd0);
        step("b5", 0, OP_ALU, 5'd0, 5'd0, 0, 0, 0, 1, 2'd0);
        step("b6", 0, OP_ALU, 5'd0, 5'd0, 0, 0, 0, 0, 2'd0);
`endif

        // ADD r4, unrelated, reader of r4 (producer sits in MEM).
        step("c1", 1, OP_ALU, 5'd1, 5'd4,  1, 0, 0, 0, 2'd0);
        step("c2", 1, OP_ALU, 5'd1, 5'd8,  1, 0, 0, 1, 2'd0);
`ifdef SRCA_FWD_EN
        step("c3", 1, OP_ALU, 5'd4, 5'd11, 1, 0, 0, 1, 2'd0);
        step("c4", 0, OP_ALU, 5'd0, 5'd0,  0, 0, 0, 1, 2'd2);
        step("c5", 0, OP_ALU, 5'd0, 5'd0,  0, 0, 0, 0, 2'd0);
`else
        step("c3", 1, OP_ALU, 5'd4, 5'd11, 0, 1, 0, 1, 2'd0);
        step("c4", 1, OP_ALU, 5'd4, 5'd11, 1, 0, 0, 0, 2'd0);
        step("c5", 0, OP_ALU, 5'd0, 5'd0,  0, 0, 0, 1, 2'd0);
        step("c6", 0, OP_ALU, 5'd0, 5'd0,  0, 0, 0, 0, 2'd0);
`endif

        // Same pattern with one more gap: producer is in WB, no forward.
        step("g1", 1, OP_ALU, 5'd1, 5'd9,  1, 0, 0, 0, 2'd0);
        step("g2", 1, OP_ALU, 5'd1, 5'd12, 1, 0, 0, 1, 2'd0);
        step("g3", 1, OP_ALU, 5'd1, 5'd13, 1, 0, 0, 1, 2'd0);
        step("g4", 1, OP_ALU, 5'd9, 5'd14, 1, 0, 0, 1, 2'd0);
        step("g5", 0, OP_ALU, 5'd0, 5'd0,  0, 0, 0, 1, 2'd0);
        step("g6", 0, OP_ALU, 5'd0, 5'd0,  0, 0, 0, 0, 2'd0);

        // JAL: one flush cycle, wrong-path instruction dropped, select 3.
        step("d1", 1, OP_JAL, 5'd0,  5'd31, 1, 0, 0, 0, 2'd0);
        step("d2", 1, OP_ALU, 5'd31, 5'd2,  0, 0, 1, 1, 2'd3);
        step("d3", 1, OP_ALU, 5'd1,  5'd2,  1, 0, 0, 0, 2'd0);
        step("d4", 0, OP_ALU, 5'd0,  5'd0,  0, 0, 0, 1, 2'd0);
        // Plain J with a nonzero rs field still issues without a hazard.
        step("d5", 1, OP_J,   5'd31, 5'd0,  1, 0, 0, 0, 2'd0);
        step("d6", 1, OP_ALU, 5'd1,  5'd2,  0, 0, 1, 1, 2'd3);
        step("d7", 0, OP_ALU, 5'd0,  5'd0,  0, 0, 0, 0, 2'd0);

        // Producer writing r0, then reader of r0.
        step("e1", 1, OP_ALU, 5'd1, 5'd0,  1, 0, 0, 0, 2'd0);
        step("e2", 1, OP_ALU, 5'd0, 5'd10, 1, 0, 0, 1, 2'd0);
        step("e3", 0, OP_ALU, 5'd0, 5'd0,  0, 0, 0, 1, 2'd0);
        step("e4", 0, OP_ALU, 5'd0, 5'd0,  0, 0, 0, 0, 2'd0);

        // Reset pulsed while in STALL, then release with the reader still held.
        step("f1", 1, OP_LW,  5'd1, 5'd5, 1, 0, 0, 0, 2'd0);
        step("f2", 1, OP_ALU, 5'd5, 5'd7, 0, 1, 0, 1, 2'd0);
        @(posedge clock);
        #1;
        resetn = 1'b0;
        checkAll("f3_reset", 0, 0, 0, 0, 2'd0);
        @(posedge clock);
        #1;
        resetn = 1'b1;
        checkAll("f4_release", 1, 0, 0, 0, 2'd0);
        step("f5", 0, OP_ALU, 5'd0, 5'd0, 0, 0, 0, 1, 2'd0);
        step("f6", 0, OP_ALU, 5'd0, 5'd0, 0, 0, 0, 0, 2'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ex_srca_ctrl.md
# ex_srca_ctrl

Issue and operand-A scheduler for the 5-stage MIPS pipeline. It tracks destinations of in-flight instructions in a shadow pipeline, decides each cycle whether the instruction in ID may issue to EX, and inserts load-use stalls and post-jump flushes. It drives the registered select for the EX-stage ALU input-A mux, choosing among register A, EX/MEM forward, MEM/WB forward and jump target.

## Interface
Parameters:
- OP_ALU, 6'd0: R-type opcode
- OP_J, 6'd2: jump opcode
- OP_JAL, 6'd3: jump-and-link opcode
- OP_ADDI, 6'd8: add-immediate opcode
- OP_LW, 6'd35: load-word opcode
- OP_SW, 6'd43: store-word opcode

Ports (one clock; reset is asynchronous and active-low):
- clock  in  1  pipeline clock, rising edge
- resetn  in  1  asynchronous active-low reset
- id_valid  in  1  ID holds a real instruction
- id_op  in  6  opcode of ID instruction
- id_rs  in  5  source register feeding ALU input A
- id_dst  in  5  destination register; 0 means no write
- id_accept  out  1  ID instruction moves to EX at this edge
- stall  out  1  hold PC and IF/ID
- flush  out  1  squash IF/ID contents
- ex_valid  out  1  EX holds a real instruction (registered)
- srca_sel  out  2  ALU-A select for EX instruction (registered): 0 IDEXA, 1 EXMEMALUOut, 2 MEM/WB result, 3 IR[25:0]<<2

## Operation
- Shadow stages EX, MEM, WB each hold {valid, dst, is_load}. They advance every cycle. On a non-accept cycle, a bubble (valid=0) enters EX.
- Hazard source: id_rs != 0, id_op is not J/JAL, a valid stage has dst == id_rs.
- Load-use: EX stage is_load, and its dst matches the hazard source → stall.
- FSM states: RUN, STALL, FLUSH.
  - RUN: id_accept = id_valid & ~hazard_stall. A load-use hazard → STALL with stall=1. An accepted J/JAL → FLUSH.
  - STALL: stall=1, id_accept=0, bubble enters EX. Re-evaluate next cycle; go to RUN when the hazard clears.
  - FLUSH: flush=1, stall=0, id_accept=0. The wrong-path ID instruction is dropped. Go to RUN next cycle unconditionally.
- Select on accept, registered into srca_sel, in priority order:
  - J/JAL → 3
  - EX dst match → 1
  - MEM dst match → 2
  - else → 0
- A load matched in MEM yields 2. A load in EX never yields 1 because it stalls instead.
- Register file writes in the first half of WB, so a WB-stage match needs no forward: select 0.
- id_valid=0 in RUN: no accept, bubble issued, no state change.

## Timing
- Reset (resetn low, async): state RUN; all shadow valid=0; ex_valid=0; srca_sel=0; stall=0; flush=0; id_accept=0.
- id_accept, stall, flush: combinational from state and ID inputs, valid in the same cycle.
- srca_sel, ex_valid: update one edge after accept, in the cycle the instruction is in EX.
- Load-use costs exactly one stall cycle, with forwarding enabled.
- Jump costs exactly one flush cycle.
- Reset mid-STALL or mid-FLUSH: returns to RUN and the pipeline is empty. The first ID instruction after release issues with select 0.
- A dst of 0 never creates a hazard or a forward.

## Configuration
- SRCA_FWD_EN defined: forwarding as above; only load-use stalls.
- SRCA_FWD_EN undefined:
  - Any hazard-source match in the EX or MEM stage stalls, up to 2 cycles.
  - srca_sel is only ever 0 or 3.
  - A WB match still needs no stall.

## Test plan
- ADD r3 issued, then ADD reading r3 next cycle → no stall; second instruction's srca_sel=1 in EX. Without SRCA_FWD_EN: 2 stall cycles, then srca_sel=0.
- LW r5, then instruction reading r5 immediately → stall=1 for exactly 1 cycle, bubble (ex_valid=0), then issue with srca_sel=2.
- ADD r4, unrelated op, then reader of r4 → srca_sel=2. The same pattern with one more gap → srca_sel=0.
- JAL accepted → flush=1 the next cycle with id_accept=0; JAL's srca_sel=3; RUN resumes after.
- Producer writing r0, then reader of r0 → no stall, srca_sel=0.
- resetn pulsed low during STALL → all outputs 0 immediately; the next valid instruction is accepted in the first cycle after release.
